// File: rtl/pe_pkg.sv
// pe_pkg: shared defaults, FSM encoding and write-select codes for pe_feeder
package pe_pkg;
  localparam int D_WIDTH_DEF = 32;
  localparam int A_WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DONE = 2'd2} state_t;
  localparam logic SEL_WEIGHT = 1'b0;
  localparam logic SEL_IACT = 1'b1;
endpackage

// File: rtl/pe_feed_buf.sv
// pe_feed_buf: DEPTH x D_WIDTH register file, one write port, one async read port
module pe_feed_buf
  import pe_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               we,
  input  logic [3:0]         waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic [3:0]         raddr,
  output logic [D_WIDTH-1:0] rdata
);
  logic [D_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/pe_feeder.sv
// pe_feeder: buffers weights/iacts written by the host and streams them to a PE on request
module pe_feeder
  import pe_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               wr_sel,
  input  logic [3:0]         wr_addr,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic               start,
  input  logic [3:0]         kernel_size,
  input  logic [3:0]         iact_size,
  input  logic               load_weight,
  input  logic               load_iact,
  output logic [D_WIDTH-1:0] weight,
  output logic [D_WIDTH-1:0] iact,
  output logic               weight_valid,
  output logic               iact_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);
  state_t state, next;
  logic [3:0] wcnt, icnt, ksize, isize;
  logic [D_WIDTH-1:0] wrd, ird;
  logic legal, launch, w_go, i_go, fin, wr_ok;
  if (A_WIDTH < 1 || DEPTH < 1) begin : g_bad_param
    $error("pe_feeder: A_WIDTH and DEPTH must be positive");
  end
  assign legal = kernel_size != 4'd0 && kernel_size <= iact_size;
  assign launch = state == IDLE && start && legal;
  assign w_go = state == STREAM && load_weight && wcnt < ksize;
  assign i_go = state == STREAM && load_iact && icnt < isize;
  assign fin = wcnt == ksize && icnt == isize;
  assign wr_ok = wr_en && state == IDLE;
  pe_feed_buf #(.D_WIDTH(D_WIDTH), .DEPTH(DEPTH)) u_wbuf (
    .clk(clk), .we(wr_ok && wr_sel == SEL_WEIGHT), .waddr(wr_addr), .wdata(wr_data),
    .raddr(wcnt), .rdata(wrd)
  );
  pe_feed_buf #(.D_WIDTH(D_WIDTH), .DEPTH(DEPTH)) u_ibuf (
    .clk(clk), .we(wr_ok && wr_sel == SEL_IACT), .waddr(wr_addr), .wdata(wr_data),
    .raddr(icnt), .rdata(ird)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE ? (launch ? STREAM : IDLE) :
           state == STREAM ? (fin ? DONE : STREAM) : IDLE;
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
  // data outputs only move on an issued request, so they hold across idle/exhausted cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wcnt <= '0;
      icnt <= '0;
      ksize <= '0;
      isize <= '0;
      weight <= '0;
      iact <= '0;
      weight_valid <= 1'b0;
      iact_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= state == IDLE && start && !legal;
      weight_valid <= w_go;
      iact_valid <= i_go;
      if (launch) begin
        ksize <= kernel_size;
        isize <= iact_size;
        wcnt <= '0;
        icnt <= '0;
      end
      if (w_go) begin
        weight <= wrd;
        wcnt <= wcnt + 4'd1;
      end
      if (i_go) begin
        iact <= ird;
        icnt <= icnt + 4'd1;
      end
    end
endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: queue-based reference model checked every cycle, plus directed literal checks
module tb_pe_feeder;
  logic clk = 0, rst = 1;
  logic wr_en = 0, wr_sel = 0, start = 0, load_weight = 0, load_iact = 0;
  logic [3:0] wr_addr = 0, kernel_size = 0, iact_size = 0;
  logic [31:0] wr_data = 0, weight, iact;
  logic weight_valid, iact_valid, busy, done, err;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  pe_feeder dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .kernel_size(kernel_size), .iact_size(iact_size),
    .load_weight(load_weight), .load_iact(load_iact), .weight(weight), .iact(iact),
    .weight_valid(weight_valid), .iact_valid(iact_valid), .busy(busy), .done(done), .err(err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: a launch snapshots the first N buffer words into queues, each request pops one
  logic [31:0] wm [16], im [16];
  logic [31:0] wq [$], iq [$];
  int phase = 0;
  logic [31:0] e_w = 0, e_i = 0;
  logic e_wv = 0, e_iv = 0, e_err = 0;
  always @(posedge clk) begin
    if (rst) begin
      phase = 0; e_w = 0; e_i = 0; e_wv = 0; e_iv = 0; e_err = 0;
      wq.delete(); iq.delete();
    end else begin
      e_wv = 0; e_iv = 0; e_err = 0;
      if (phase == 0) begin
        if (wr_en) begin
          if (wr_sel) im[wr_addr] = wr_data;
          else wm[wr_addr] = wr_data;
        end
        if (start && kernel_size != 0 && kernel_size <= iact_size) begin
          wq.delete(); iq.delete();
          for (int k = 0; k < int'(kernel_size); k++) wq.push_back(wm[k]);
          for (int k = 0; k < int'(iact_size); k++) iq.push_back(im[k]);
          phase = 1;
        end else if (start) e_err = 1;
      end else if (phase == 1) begin
        if (wq.size() == 0 && iq.size() == 0) phase = 2;
        else begin
          if (load_weight && wq.size() != 0) begin e_w = wq.pop_front(); e_wv = 1; end
          if (load_iact && iq.size() != 0) begin e_i = iq.pop_front(); e_iv = 1; end
        end
      end else phase = 0;
    end
  end
  logic [31:0] cap_w [$], cap_i [$];
  logic iv_hist [$];
  int done_cnt = 0, err_cnt = 0;
  always @(posedge clk) begin
    #1;
    chk("weight", weight, e_w);
    chk("iact", iact, e_i);
    chk("weight_valid", weight_valid, e_wv);
    chk("iact_valid", iact_valid, e_iv);
    chk("busy", busy, phase != 0);
    chk("done", done, phase == 2);
    chk("err", err, e_err);
    if (weight_valid) cap_w.push_back(weight);
    if (iact_valid) cap_i.push_back(iact);
    iv_hist.push_back(iact_valid);
    if (done) done_cnt++;
    if (err) err_cnt++;
  end
  task automatic write(input logic s, input logic [3:0] a, input logic [31:0] d);
    wr_en = 1; wr_sel = s; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask
  task automatic go(input logic [3:0] ks, input logic [3:0] is);
    start = 1; kernel_size = ks; iact_size = is;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_idle();
    for (int k = 0; k < 100 && busy; k++) @(negedge clk);
    chk("idle_timeout", busy, 0);
  endtask
  task automatic clear_caps();
    cap_w.delete(); cap_i.delete(); done_cnt = 0; err_cnt = 0;
  endtask
  task automatic chk_full_stream(input string tag);
    chk({tag, "_wcount"}, cap_w.size(), 3);
    chk({tag, "_icount"}, cap_i.size(), 5);
    for (int k = 0; k < 3 && k < cap_w.size(); k++) chk({tag, "_wdata"}, cap_w[k], k + 2);
    for (int k = 0; k < 5 && k < cap_i.size(); k++) chk({tag, "_idata"}, cap_i[k], k + 1);
    chk({tag, "_done_cnt"}, done_cnt, 1);
  endtask
  initial begin
    @(negedge clk); @(negedge clk);
    chk("rst_weight", weight, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    for (int k = 0; k < 3; k++) write(0, 4'(k), k + 2);
    for (int k = 0; k < 5; k++) write(1, 4'(k), k + 1);
    // basic 3/5 stream with both loads held high
    clear_caps();
    load_weight = 1; load_iact = 1;
    go(3, 5);
    wait_idle();
    chk_full_stream("basic");
    // kernel larger than iact window is illegal
    clear_caps();
    go(4, 3);
    chk("illegal_busy", busy, 0);
    @(negedge clk);
    chk("illegal_err_cnt", err_cnt, 1);
    chk("illegal_valids", cap_w.size() + cap_i.size(), 0);
    go(0, 3);
    chk("zero_kernel_err_cnt", err_cnt, 2);
    // extra weight requests after exhaustion, plus a dropped write mid-stream
    clear_caps();
    go(3, 5);
    write(0, 0, 99);
    wait_idle();
    chk("hold_weight", weight, 4);
    chk("hold_weight_valid", weight_valid, 0);
    chk("hold_wcount", cap_w.size(), 3);
    clear_caps();
    go(3, 5);
    wait_idle();
    chk_full_stream("rerun");
    // reset part-way through the iact stream
    clear_caps();
    go(3, 5);
    for (int k = 0; k < 50 && cap_i.size() < 2; k++) @(negedge clk);
    chk("rst_wait", cap_i.size(), 2);
    rst = 1;
    #1;
    chk("async_weight", weight, 0);
    chk("async_iact", iact, 0);
    chk("async_valids", {weight_valid, iact_valid}, 0);
    chk("async_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    clear_caps();
    go(3, 5);
    wait_idle();
    chk_full_stream("after_rst");
    // toggled iact requests, weight requests off
    clear_caps();
    load_weight = 0; load_iact = 0;
    go(3, 5);
    iv_hist.delete();
    for (int k = 0; k < 4; k++) begin
      load_iact = (k % 2 == 0);
      @(negedge clk);
    end
    chk("toggle_hist_len", iv_hist.size(), 4);
    if (iv_hist.size() >= 4) chk("toggle_pattern", {iv_hist[0], iv_hist[1], iv_hist[2], iv_hist[3]}, 4'b1010);
    chk("toggle_icount", cap_i.size(), 2);
    if (cap_i.size() >= 2) chk("toggle_second_iact", cap_i[1], 2);
    chk("toggle_no_weight", cap_w.size(), 0);
    load_weight = 1; load_iact = 1;
    wait_idle();
    chk("toggle_total_i", cap_i.size(), 5);
    chk("toggle_done", done_cnt, 1);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
